encoder_128_7: RTL
==================

// Module: encoder_128_7
// PURPOSE
//  Pipelined 128:7 priority encoder; inverse of the cache 7:128 block decoder.
//  Converts a 128-bit block vector (tag-hit lines, valid/free bits) to a 7-bit block_address.
//  Sits between the cache tag-compare array and the block-select / replacement logic.
//  Two register stages with valid/ready flow control; lowest set index wins.
// PARAMETERS
//  WIDTH   128  input vector width; fixed, must equal 2**ADDR_W
//  ADDR_W  7    encoded address width
//  GRP     8    stage-1 group size; WIDTH/GRP = 16 groups
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       asynchronous, active-low reset
//  in_valid     in   1       in_vec valid this cycle
//  in_ready     out  1       block accepts in_vec this cycle
//  in_vec       in   128     block vector to encode
//  out_valid    out  1       out_* fields valid
//  out_ready    in   1       consumer accepts result
//  out_addr     out  7       index of lowest set bit of in_vec; 0 if none
//  out_found    out  1       in_vec had at least one bit set
//  out_multi    out  1       in_vec had more than one bit set (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n low, async): s1_valid=0, s2_valid=0; out_valid=0, out_addr=0,
//    out_found=0, out_multi=0; in_ready=1 once out of reset. Reset mid-transfer drops data.
//  - Transfer on in_valid&in_ready (input) and out_valid&out_ready (output).
//  - Stage 1 (S1): per 8-bit group g: grp_any[g]=|bits, grp_idx[g]=lowest set bit (3b),
//    grp_cnt2[g]=more-than-one-set flag. Registered with s1_valid.
//  - Stage 2 (S2): lowest g with grp_any[g]; out_addr={g[3:0],grp_idx[g]};
//    out_found=|grp_any. Registered with s2_valid = out_valid.
//  - Flow: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv;
//    in_ready = s1_adv (combinational from out_ready, no skid buffer).
//  - Latency: 2 cycles accept-to-out_valid; throughput 1/cycle with out_ready high.
//  - Stall: out_ready low holds out_* stable while out_valid=1; S1 holds if S2 full.
//  - Bubbles: a stage with valid=0 loads when its advance is true; data regs only
//    update when the stage loads a valid entry (no toggling on bubbles).
//  - Zero vector: out_found=0, out_addr=0, out_multi=0.
//  - Priority: lowest index wins, e.g. bits 5 and 100 -> out_addr=5.
//  - Order preserved; no drop or duplication under any out_ready pattern.
// CONFIGURATION
//  - Macro ENC_MULTIHOT_DET_EN:
//    defined   -> out_multi=1 when >1 bit set: any grp_cnt2, or >=2 grp_any
//                 (S2). Aligned with out_addr.
//    undefined -> grp_cnt2 logic not built; out_multi tied 0. Port list unchanged.
// STRUCTURE
//  - Package enc_pkg: localparams WIDTH, ADDR_W, GRP, NGRP=WIDTH/GRP, GIDX_W=3;
//    typedef s1_t {grp_any[NGRP], grp_idx[NGRP][3], grp_cnt2[NGRP]}.
//  - Sub-module prio_enc #(N): N-bit vector -> any, lowest idx ($clog2(N)), multi.
//    16x N=8 in S1, 1x N=16 in S2.
//  - Top: two pipeline registers plus flow-control logic only.
// TESTING
//  1 Sweep k=0..127: in_vec=1<<k, out_ready=1 -> out_addr=k, out_found=1, out_multi=0, 2-cycle latency.
//  2 in_vec=0 -> out_found=0, out_addr=0, out_multi=0.
//  3 in_vec bits 5,100 -> out_addr=5, out_found=1; out_multi=1 with ENC_MULTIHOT_DET_EN, 0 without.
//  4 Back-to-back 1<<3,1<<64,1<<127, out_ready low 4 cycles after first out_valid ->
//    out_addr held 3; in_ready low once both stages full; then 3,64,127 in order, none lost.
//  5 Random in_vec and random in_valid/out_ready (10k txns) vs lowest-index reference model; exact match.
//  6 reset_n low with both stages valid -> same cycle out_valid=0, all outputs 0; clean restart.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the encoder_128_7 pipelined priority encoder.
// Holds the fixed geometry (128-bit vector, 8-bit groups, 16 groups) and the
// stage-1 pipeline record carried between the two register stages.
package enc_pkg;

   localparam int WIDTH  = 128;               // input vector width, 2**ADDR_W
   localparam int ADDR_W = 7;                 // encoded address width
   localparam int GRP    = 8;                 // stage-1 group size
   localparam int NGRP   = WIDTH / GRP;       // 16 groups
   localparam int GIDX_W = 3;                 // index within a group
   localparam int GSEL_W = ADDR_W - GIDX_W;   // group number width (4)

   // Per-group summary produced by stage 1 and consumed by stage 2.
   typedef struct packed {
      logic [NGRP-1:0]             grp_any;   // group has any bit set
      logic [NGRP-1:0][GIDX_W-1:0] grp_idx;   // lowest set bit inside group
      logic [NGRP-1:0]             grp_cnt2;  // group has more than one bit set
   } s1_t;

endpackage

// File: rtl/prio_enc.sv
// Generic combinational lowest-index priority encoder.
// Ports:
//   vec   in   N            vector to encode
//   any   out  1            at least one bit of vec is set
//   idx   out  $clog2(N)    index of lowest set bit; 0 when vec is zero
//   multi out  1            more than one bit set (constant 0 when MULTI_EN=0)
module prio_enc #(
   parameter int N        = 8,
   parameter bit MULTI_EN = 1'b1
) (
   input  logic [N-1:0]         vec,
   output logic                 any,
   output logic [$clog2(N)-1:0] idx,
   output logic                 multi
);

   localparam int IW = $clog2(N);

   assign any = |vec;

   // Scan from the top down so the last (lowest) set bit overwrites idx.
   always_comb begin
      // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end

   generate
      if (MULTI_EN) begin : g_multi
         // Clearing the lowest set bit leaves something only if a second bit exists.
         assign multi = |(vec & (vec - N'(1)));
      end else begin : g_no_multi
         assign multi = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/encoder_128_7.sv
// Pipelined 128:7 priority encoder (lowest set index wins), the inverse of the
// cache 7:128 block decoder. Stage 1 encodes sixteen 8-bit groups; stage 2
// picks the lowest non-empty group. Two register stages, valid/ready handshake
// on both sides, 2-cycle latency, 1 result per cycle with out_ready high.
// Optional feature macro: ENC_MULTIHOT_DET_EN enables multi-hot detection on
// out_multi; without it out_multi is tied 0 and the per-group count logic is
// not built.
// Ports:
//   clk        in   1    rising-edge clock
//   reset_n    in   1    asynchronous active-low reset
//   in_valid   in   1    in_vec valid this cycle
//   in_ready   out  1    block accepts in_vec this cycle
//   in_vec     in   128  block vector to encode
//   out_valid  out  1    out_* fields valid
//   out_ready  in   1    consumer accepts result
//   out_addr   out  7    index of lowest set bit; 0 if none
//   out_found  out  1    in_vec had at least one bit set
//   out_multi  out  1    in_vec had more than one bit set
module encoder_128_7
   import enc_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_vec,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_found,
   output logic              out_multi
);

`ifdef ENC_MULTIHOT_DET_EN
   localparam bit MULTI_EN = 1'b1;
`else
   localparam bit MULTI_EN = 1'b0;
`endif

   logic s1_valid, s2_valid;
   logic s1_adv, s2_adv;
   s1_t  s1_d, s1_q;

   // Flow control: a stage may load when it is empty or its content moves on.
   // in_ready is combinational from out_ready; there is no skid buffer.
   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // ---------------- Stage 1: per-group encode ----------------
   logic [NGRP-1:0]             grp_any;
   logic [NGRP-1:0][GIDX_W-1:0] grp_idx;
   logic [NGRP-1:0]             grp_cnt2;

   for (genvar g = 0; g < NGRP; g++) begin : g_grp
      prio_enc #(.N(GRP), .MULTI_EN(MULTI_EN)) u_grp (
         .vec   (in_vec[g*GRP +: GRP]),
         .any   (grp_any[g]),
         .idx   (grp_idx[g]),
         .multi (grp_cnt2[g])
      );
   end

   assign s1_d = '{grp_any: grp_any, grp_idx: grp_idx, grp_cnt2: grp_cnt2};

   // NOTE: data registers are reset too, because every output must read zero during reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: non-blocking assignments for all clocked state so stages update together.
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         // Data only changes on a real load; bubbles leave it untouched.
         if (in_valid) s1_q <= s1_d;
      end
   end

   // ---------------- Stage 2: group select ----------------
   logic              sel_found;
   logic [GSEL_W-1:0] sel_grp;
   logic              sel_multi_grp;
   logic [ADDR_W-1:0] s2_addr_d;
   logic              s2_multi_d;

   prio_enc #(.N(NGRP), .MULTI_EN(MULTI_EN)) u_sel (
      .vec   (s1_q.grp_any),
      .any   (sel_found),
      .idx   (sel_grp),
      .multi (sel_multi_grp)
   );

   // An empty vector selects group 0, whose stored index is 0, giving address 0.
   assign s2_addr_d = {sel_grp, s1_q.grp_idx[sel_grp]};

`ifdef ENC_MULTIHOT_DET_EN
   // Multi-hot: two bits inside one group, or two or more non-empty groups.
   assign s2_multi_d = sel_multi_grp || (|s1_q.grp_cnt2);
`else
   logic unused_multi;
   assign unused_multi = ^{sel_multi_grp, s1_q.grp_cnt2};
   assign s2_multi_d   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid  <= 1'b0;
         out_addr  <= '0;
         out_found <= 1'b0;
         out_multi <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_addr  <= s2_addr_d;
            out_found <= sel_found;
            out_multi <= s2_multi_d;
         end
      end
   end

   assign out_valid = s2_valid;

endmodule
